// File: rtl/uart_tx_serializer.sv
// UART transmitter: one byte per accepted request, sent LSB first as 8N1.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit (8E1).
module uart_tx_serializer #(
  parameter int unsigned CLK_FREQ  = 25_000_000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 clk_in,
  input  logic                 n_rst,
  input  logic                 uart_tx_en_in,
  input  logic [DATA_BITS-1:0] uart_tx_data_in,
  output logic                 uart_tx_ready_out,
  output logic                 uart_tx_serial_out,
  output logic                 uart_tx_done_out
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W        = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;
`endif

  state_t               r_state;
  logic [DATA_BITS-1:0] r_shift;
  logic [CNT_W-1:0]     r_bit_cnt;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_serial;
  logic                 r_ready;
  logic                 r_done;
`ifdef UART_TX_PARITY_EN
  logic                 r_parity;
`endif

  logic w_bit_end;
  logic w_last_bit;

  // A bit period ends when the counter wraps; the line only moves then.
  assign w_bit_end  = (r_bit_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign w_last_bit = (r_idx == IDX_W'(DATA_BITS - 1));

  always_ff @(posedge clk_in or negedge n_rst) begin
    if (!n_rst) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_idx     <= '0;
      r_serial  <= 1'b1;
      r_ready   <= 1'b1;
      r_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_serial  <= 1'b1;
          r_ready   <= 1'b1;
          r_bit_cnt <= '0;
          r_idx     <= '0;
          // Start bit goes out on the accepting edge itself, no bubble.
          if (uart_tx_en_in) begin
            r_shift  <= uart_tx_data_in;
            r_state  <= START;
            r_serial <= 1'b0;
            r_ready  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity <= ^uart_tx_data_in;
`endif
          end
        end

        START: begin
          if (w_bit_end) begin
            r_bit_cnt <= '0;
            r_idx     <= '0;
            r_serial  <= r_shift[0];
            r_shift   <= r_shift >> 1;
            r_state   <= DATA;
          end else begin
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
          end
        end

        DATA: begin
          if (w_bit_end) begin
            r_bit_cnt <= '0;
            if (w_last_bit) begin
`ifdef UART_TX_PARITY_EN
              r_serial <= r_parity;
              r_state  <= PARITY;
`else
              r_serial <= 1'b1;
              r_state  <= STOP;
`endif
            end else begin
              r_idx    <= r_idx + IDX_W'(1);
              r_serial <= r_shift[0];
              r_shift  <= r_shift >> 1;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (w_bit_end) begin
            r_bit_cnt <= '0;
            r_serial  <= 1'b1;
            r_state   <= STOP;
          end else begin
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
          end
        end
`endif

        STOP: begin
          // Ready and done rise together so a new request can land next edge.
          if (w_bit_end) begin
            r_bit_cnt <= '0;
            r_state   <= IDLE;
            r_done    <= 1'b1;
            r_ready   <= 1'b1;
          end else begin
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
          end
        end

        default: begin
          r_state   <= IDLE;
          r_serial  <= 1'b1;
          r_ready   <= 1'b1;
          r_bit_cnt <= '0;
          r_idx     <= '0;
        end
      endcase
    end
  end

  assign uart_tx_ready_out  = r_ready;
  assign uart_tx_serial_out = r_serial;
  assign uart_tx_done_out   = r_done;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer: stimulus queues expected frames,
// a line monitor decodes each frame and checks it against the queue.
module tb_uart_tx_serializer;

  localparam int CPB = 10;
  localparam int DB  = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NSLOT = DB + 3;
`else
  localparam int NSLOT = DB + 2;
`endif
  localparam int FLEN = NSLOT * CPB;

  typedef struct {
    logic [7:0] data;
    logic       par;
    bit         b2b;
  } exp_t;

  logic       clk_in = 1'b0;
  logic       n_rst;
  logic       en;
  logic [7:0] data;
  logic       ready;
  logic       serial;
  logic       done;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   n_exp = 0;
  int   done_cnt = 0;
  int   cyc = 0;
  int   last_done_cyc = 0;
  logic prev_line = 1'b1;

  uart_tx_serializer #(
    .CLK_FREQ (1_000_000),
    .BAUD     (100_000),
    .DATA_BITS(8)
  ) dut (
    .clk_in            (clk_in),
    .n_rst             (n_rst),
    .uart_tx_en_in     (en),
    .uart_tx_data_in   (data),
    .uart_tx_ready_out (ready),
    .uart_tx_serial_out(serial),
    .uart_tx_done_out  (done)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  always @(negedge clk_in) if (n_rst && done) done_cnt <= done_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Decode one frame starting at the negedge where the start bit was seen.
  task automatic decode_frame();
    logic [NSLOT-1:0] slots;
    logic             slot_val;
    logic [7:0]       got;
    bit               stable, busy_ok, early, aborted;
    int               start_c;
    exp_t             e;
    slots    = '0;
    slots[0] = serial;
    slot_val = serial;
    stable   = 1;
    busy_ok  = (ready === 1'b0);
    early    = (done === 1'b1);
    aborted  = 0;
    start_c  = cyc;
    for (int t = 1; t < FLEN; t++) begin
      @(negedge clk_in);
      if (!n_rst) begin
        aborted = 1;
        break;
      end
      if (t % CPB == 0) begin
        slot_val = serial;
        slots[t / CPB] = serial;
      end else if (serial !== slot_val) begin
        stable = 0;
      end
      if (ready !== 1'b0) busy_ok = 0;
      if (done !== 1'b0) early = 1;
    end
    if (aborted) return;
    @(negedge clk_in);
    if (!n_rst) return;
    got = slots[DB:1];
    check("frame_expected", 32'(q.size() != 0), 32'd1);
    if (q.size() == 0) return;
    e = q.pop_front();
    check("start_bit", 32'(slots[0]), 32'd0);
    check("data_byte", 32'(got), 32'(e.data));
`ifdef UART_TX_PARITY_EN
    check("parity_bit", 32'(slots[DB+1]), 32'(e.par));
`endif
    check("stop_bit", 32'(slots[NSLOT-1]), 32'd1);
    check("bit_stable", 32'(stable), 32'd1);
    check("ready_low_busy", 32'(busy_ok), 32'd1);
    check("no_early_done", 32'(early), 32'd0);
    check("done_at_frame_end", 32'(done), 32'd1);
    check("ready_at_frame_end", 32'(ready), 32'd1);
    if (e.b2b) check("b2b_gap", 32'(start_c - last_done_cyc), 32'd1);
    last_done_cyc = cyc;
  endtask

  // Line monitor: a falling edge on an idle line starts a frame.
  initial begin
    forever begin
      @(negedge clk_in);
      if (!n_rst) begin
        prev_line = 1'b1;
      end else begin
        if (prev_line && !serial) decode_frame();
        prev_line = serial;
      end
    end
  end

  // Called at a negedge; en is sampled at the following posedge.
  task automatic send(input logic [7:0] d, input bit push, input bit b2b, input logic par);
    exp_t e;
    check("ready_before_en", 32'(ready), 32'd1);
    en   = 1'b1;
    data = d;
    if (push) begin
      e.data = d;
      e.par  = par;
      e.b2b  = b2b;
      q.push_back(e);
      n_exp++;
    end
    @(negedge clk_in);
    en   = 1'b0;
    data = ~d;
    check("accept_serial_low", 32'(serial), 32'd0);
    check("accept_ready_low", 32'(ready), 32'd0);
  endtask

  task automatic wait_ready();
    bit found;
    found = 0;
    for (int i = 0; i < 2 * FLEN; i++) begin
      if (ready === 1'b1) begin
        found = 1;
        break;
      end
      @(negedge clk_in);
    end
    check("ready_seen", 32'(found), 32'd1);
  endtask

  task automatic wait_done();
    bit found;
    found = 0;
    for (int i = 0; i < FLEN + 20; i++) begin
      @(negedge clk_in);
      if (done === 1'b1) begin
        found = 1;
        break;
      end
    end
    check("done_seen", 32'(found), 32'd1);
  endtask

  logic [7:0] fifo_mem [4];
  logic       fifo_par [4];
  int         d0;

  initial begin
    fifo_mem[0] = 8'h00; fifo_par[0] = 1'b0;
    fifo_mem[1] = 8'h01; fifo_par[1] = 1'b1;
    fifo_mem[2] = 8'h02; fifo_par[2] = 1'b1;
    fifo_mem[3] = 8'h03; fifo_par[3] = 1'b0;

    n_rst = 1'b0;
    en    = 1'b0;
    data  = 8'h00;
    repeat (2) @(negedge clk_in);
    check("rst_serial", 32'(serial), 32'd1);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    n_rst = 1'b1;
    repeat (3) @(negedge clk_in);
    check("idle_serial", 32'(serial), 32'd1);
    check("idle_ready", 32'(ready), 32'd1);

    // 0x55: four ones, even parity 0
    send(8'h55, 1, 0, 1'b0);
    wait_done();
    repeat (3) @(negedge clk_in);

    // 0xA5 parity 0, 0x07 parity 1
    send(8'hA5, 1, 0, 1'b0);
    wait_done();
    @(negedge clk_in);
    send(8'h07, 1, 0, 1'b1);
    wait_done();
    repeat (2) @(negedge clk_in);

    // Request while busy: 0xFF at cycle 30 of a 0x00 frame is dropped
    d0 = done_cnt;
    send(8'h00, 1, 0, 1'b0);
    repeat (28) @(negedge clk_in);
    en   = 1'b1;
    data = 8'hFF;
    @(negedge clk_in);
    en = 1'b0;
    check("busy_ready_low", 32'(ready), 32'd0);
    wait_done();
    repeat (5) @(negedge clk_in);
    check("busy_one_done", 32'(done_cnt - d0), 32'd1);

    // Back-to-back: 0x31 requested in the done cycle of 0x30
    send(8'h30, 1, 0, 1'b0);
    wait_done();
    send(8'h31, 1, 1, 1'b1);
    wait_done();
    repeat (3) @(negedge clk_in);

    // Reset mid-frame: line high at once, no done afterwards
    wait_ready();
    send(8'h3C, 0, 0, 1'b0);
    repeat (33) @(negedge clk_in);
    d0 = done_cnt;
    #2 n_rst = 1'b0;
    #1;
    check("midrst_serial", 32'(serial), 32'd1);
    check("midrst_ready", 32'(ready), 32'd1);
    check("midrst_done", 32'(done), 32'd0);
    repeat (3) @(negedge clk_in);
    n_rst = 1'b1;
    repeat (150) @(negedge clk_in);
    check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    check("midrst_line_idle", 32'(serial), 32'd1);

    // Controller read run: registered en one cycle after seeing ready
    for (int i = 0; i < 4; i++) begin
      wait_ready();
      @(negedge clk_in);
      send(fifo_mem[i], 1, 0, fifo_par[i]);
    end
    wait_done();
    repeat (5) @(negedge clk_in);

    check("queue_drained", 32'(q.size()), 32'd0);
    check("done_count", 32'(done_cnt), 32'(n_exp));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
